// File: rtl/uart_mmio_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// register bit positions, shifter state encoding and the STATUS word layout.
package uart_mmio_tx_pkg;

   localparam int unsigned REG_STATUS = 0;
   localparam int unsigned REG_DATA   = 1;
   localparam int unsigned REG_CTRL   = 2;

   localparam int unsigned CT_EN      = 0;
   localparam int unsigned CT_IRQ_EN  = 1;
   localparam int unsigned CT_OVF_CLR = 2;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   typedef struct packed {
      logic [7:0] count;
      logic [3:0] rsvd;
      logic       ovf;
      logic       busy;
      logic       empty;
      logic       ready;
   } status_t;

   // Rounded clock cycles per bit.
   function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; full/empty come from the count
// register so a push while full is dropped even if a pop happens that cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic             clock,
   input  logic             n_rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_c_o,
   output logic             full_c_o,
   output logic             empty_c_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             push_ok_c, pop_ok_c;

   assign full_c_o  = (count_q == CW'(DEPTH));
   assign empty_c_o = (count_q == '0);
   assign push_ok_c = push_i & ~full_c_o;
   assign pop_ok_c  = pop_i & ~empty_c_o;
   assign rdata_c_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(push_ok_c) - CW'(pop_ok_c);
      if (push_ok_c) wr_ptr_d = AW'((32'(wr_ptr_q) + 32'd1) % DEPTH);
      if (pop_ok_c)  rd_ptr_d = AW'((32'(rd_ptr_q) + 32'd1) % DEPTH);
   end

   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: pointers and count define validity.
   always_ff @(posedge clock) begin
      if (push_ok_c) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_mmio_tx.sv
// Memory-mapped UART transmitter: STATUS/DATA/CTRL register window in front of
// a TX FIFO and a start/data/parity/stop shifter.
module uart_mmio_tx
   import uart_mmio_tx_pkg::*;
#(
   parameter int unsigned       ADDR_W     = 12,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'('h800),
   parameter int unsigned       FIFO_DEPTH = 16,
   parameter int unsigned       CLK_HZ     = 50_000_000,
   parameter int unsigned       BAUD       = 115200,
   parameter int unsigned       PARITY     = 0,
   parameter int unsigned       STOP_BITS  = 1
) (
   input  logic              clock,
   input  logic              n_rst,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic [15:0]       bus_wdata,
   input  logic              bus_we,
   output logic              bus_sel,
   output logic [15:0]       bus_rdata,
   output logic              tx,
   output logic              irq
);

   localparam int unsigned DIV     = calc_div(CLK_HZ, BAUD);
   localparam int unsigned BW      = $clog2(DIV);
   localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
   localparam bit          HAS_PAR = (PARITY != 0);
   localparam logic        ODD_PAR = (PARITY == 2);

   logic [ADDR_W-1:0] off_c;
   logic              wr_data_c, wr_ctrl_c;
   logic [7:0]        fifo_rdata_c;
   logic              fifo_full_c, fifo_empty_c;
   logic [CW-1:0]     fifo_count;
   logic [8:0]        count_ext_c;
   logic              pop_c, can_pop_c, bit_end_c, busy_c;
   status_t           status_c;
   logic              unused_ok;

   logic              en_q, en_d, irq_en_q, irq_en_d, ovf_q, ovf_d;
   logic              irq_q, irq_d, tx_q, tx_d, par_q, par_d;
   logic [15:0]       rdata_q, rdata_d;
   tx_state_e         state_q, state_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [2:0]        idx_q, idx_d;
   logic [7:0]        shreg_q, shreg_d;

   // Window decode: offset wraps, so anything below BASE_ADDR misses too.
   assign off_c     = bus_addr - BASE_ADDR;
   assign bus_sel   = (off_c < ADDR_W'(3));
   assign wr_data_c = bus_we & bus_sel & (off_c == ADDR_W'(REG_DATA));
   assign wr_ctrl_c = bus_we & bus_sel & (off_c == ADDR_W'(REG_CTRL));
   assign unused_ok = ^bus_wdata[15:8];

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock     (clock),
      .n_rst     (n_rst),
      .push_i    (wr_data_c),
      .wdata_i   (bus_wdata[7:0]),
      .pop_i     (pop_c),
      .rdata_c_o (fifo_rdata_c),
      .full_c_o  (fifo_full_c),
      .empty_c_o (fifo_empty_c),
      .count_o   (fifo_count)
   );

   // Control and sticky overflow; a same-cycle overflow beats the clear.
   always_comb begin
      en_d     = en_q;
      irq_en_d = irq_en_q;
      ovf_d    = ovf_q;
      if (wr_ctrl_c) begin
         en_d     = bus_wdata[CT_EN];
         irq_en_d = bus_wdata[CT_IRQ_EN];
         if (bus_wdata[CT_OVF_CLR]) ovf_d = 1'b0;
      end
      if (wr_data_c && fifo_full_c) ovf_d = 1'b1;
   end

   assign count_ext_c = 9'(fifo_count);

   always_comb begin
      status_c       = '0;
      status_c.ready = ~fifo_full_c;
      status_c.empty = fifo_empty_c;
      status_c.busy  = busy_c;
      status_c.ovf   = ovf_q;
      status_c.count = count_ext_c[8] ? 8'hFF : count_ext_c[7:0];
   end

   always_comb begin
      rdata_d = '0;
      if (bus_sel && off_c == ADDR_W'(REG_STATUS))    rdata_d = status_c;
      else if (bus_sel && off_c == ADDR_W'(REG_CTRL)) rdata_d = {14'd0, irq_en_q, en_q};
   end

   assign irq_d     = fifo_empty_c & irq_en_q;
   assign can_pop_c = en_q & ~fifo_empty_c;
   assign bit_end_c = (bit_cnt_q == BW'(DIV - 1));

   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= TX_IDLE;
         bit_cnt_q <= '0;
         idx_q     <= '0;
         shreg_q   <= '0;
         par_q     <= 1'b0;
         tx_q      <= 1'b1;
         en_q      <= 1'b1;
         irq_en_q  <= 1'b0;
         ovf_q     <= 1'b0;
         irq_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         par_q     <= par_d;
         tx_q      <= tx_d;
         en_q      <= en_d;
         irq_en_q  <= irq_en_d;
         ovf_q     <= ovf_d;
         irq_q     <= irq_d;
         rdata_q   <= rdata_d;
      end
   end

   // Shifter next state; the last stop cycle may pop directly so frames abut.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      par_d     = par_q;
      pop_c     = 1'b0;
      if (state_q != TX_IDLE) bit_cnt_d = bit_end_c ? '0 : bit_cnt_q + BW'(1);
      unique case (state_q)
         TX_IDLE:   pop_c = can_pop_c;
         TX_START:  if (bit_end_c) state_d = TX_DATA;
         TX_DATA: begin
            if (bit_end_c) begin
               shreg_d = {1'b0, shreg_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = HAS_PAR ? TX_PARITY : TX_STOP;
            end
         end
         TX_PARITY: if (bit_end_c) state_d = TX_STOP;
         TX_STOP: begin
            if (bit_end_c) begin
               if (idx_q == 3'(STOP_BITS - 1)) begin
                  state_d = TX_IDLE;
                  idx_d   = '0;
                  pop_c   = can_pop_c;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default:   state_d = TX_IDLE;
      endcase
      if (pop_c) begin
         state_d   = TX_START;
         bit_cnt_d = '0;
         idx_d     = '0;
         shreg_d   = fifo_rdata_c;
         par_d     = (^fifo_rdata_c) ^ ODD_PAR;
      end
   end

   // Line level per state; registered into tx one cycle later.
   always_comb begin
      tx_d   = 1'b1;
      busy_c = (state_q != TX_IDLE);
      unique case (state_q)
         TX_START:  tx_d = 1'b0;
         TX_DATA:   tx_d = shreg_q[0];
         TX_PARITY: tx_d = par_q;
         default:   tx_d = 1'b1;
      endcase
   end

   assign tx        = tx_q;
   assign irq       = irq_q;
   assign bus_rdata = rdata_q;

endmodule
